pixel_readout_ctrl: RTL and testbench

//  Consumer side of the pixel-array control interface (erase/expose/convert/read).

---
 rtl/pixel_readout_ctrl_if.sv | 27 ++
 rtl/pixel_readout_ctrl.sv | 131 +++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_readout_ctrl_if.sv
// Frame-sink stream port of the pixel readout controller.
// The controller drives word, index and valid; the sink answers with ready.
interface pixel_readout_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int N_PIX  = 4
);
  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pixel_readout_ctrl.sv
// Pixel-array readout: phase strobes to analog gates, saturating ramp for convert,
// frame capture on read and valid/ready streaming of the captured words.
//
// capture state | meaning
// ST_IDLE       | armed, waiting for read to rise
// ST_SETTLE     | first read cycle seen; a second read cycle is the capture point
// ST_FULL       | this read phase already handled; wait for read to drop before re-arming
module pixel_readout_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_PIX  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    erase,
  input  logic                    expose,
  input  logic                    convert,
  input  logic                    read,
  output logic                    bias_en,
  output logic                    ramp_en,
  output logic                    bus_oe,
  output logic [DATA_W-1:0]       dac_code,
  input  logic [N_PIX*DATA_W-1:0] pix_data,
  pixel_readout_ctrl_if.master    sink,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    proto_err
);

  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [DATA_W-1:0] DAC_MAX  = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FULL   = 2'd2
  } cap_state_t;

  cap_state_t        cap_state;
  logic [DATA_W-1:0] frame_buf [N_PIX];
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              ramp_en_q;
  logic              bus_oe_q;
  logic [DATA_W-1:0] dac_q;

  logic [2:0] strobe_cnt;
  logic       accept;
  logic       last_accept;
  logic       cap_point;
  logic       buf_busy;

  always_comb begin
    strobe_cnt  = 3'({2'b00, erase}) + 3'({2'b00, expose})
                + 3'({2'b00, convert}) + 3'({2'b00, read});
    accept      = valid_q & sink.out_ready;
    last_accept = accept & (idx_q == LAST_IDX);
    cap_point   = (cap_state == ST_SETTLE) & read;
    // A frame finishing this very cycle frees the buffer for the incoming one.
    buf_busy    = valid_q & ~last_accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state  <= ST_IDLE;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      ramp_en_q  <= 1'b0;
      bus_oe_q   <= 1'b0;
      bias_en    <= 1'b0;
      dac_q      <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      proto_err  <= 1'b0;
      for (int i = 0; i < N_PIX; i++) begin
        frame_buf[i] <= '0;
      end
    end else begin
      bias_en    <= expose;
      ramp_en_q  <= convert;
      bus_oe_q   <= convert & ~read;
      frame_done <= last_accept;

      if (erase || !convert) begin
        dac_q <= '0;
      end else if (dac_q != DAC_MAX) begin
        dac_q <= dac_q + 1'b1;
      end

      if (strobe_cnt > 3'd1) begin
        proto_err <= 1'b1;
      end

      case (cap_state)
        ST_IDLE:   if (read) cap_state <= ST_SETTLE;
        ST_SETTLE: cap_state <= read ? ST_FULL : ST_IDLE;
        ST_FULL:   if (!read) cap_state <= ST_IDLE;
        default:   cap_state <= ST_IDLE;
      endcase

      if (cap_point && !buf_busy) begin
        for (int i = 0; i < N_PIX; i++) begin
          frame_buf[i] <= pix_data[i*DATA_W +: DATA_W];
        end
        idx_q   <= '0;
        valid_q <= 1'b1;
      end else if (accept) begin
        if (last_accept) begin
          idx_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end

      if (cap_point && buf_busy) begin
        overrun <= 1'b1;
      end
    end
  end

  // Analog gates are forced off during a reset cycle, not just the one after it.
  assign ramp_en  = ramp_en_q & ~reset;
  assign bus_oe   = bus_oe_q & ~reset;
  assign dac_code = dac_q;

  assign sink.out_data  = frame_buf[idx_q];
  assign sink.out_idx   = idx_q;
  assign sink.out_valid = valid_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl: ramp, capture, streaming, overrun and reset.
module tb_pixel_readout_ctrl;

  logic        clk;
  logic        reset;
  logic        erase;
  logic        expose;
  logic        convert;
  logic        read;
  logic        bias_en;
  logic        ramp_en;
  logic        bus_oe;
  logic [7:0]  dac_code;
  logic [31:0] pix_data;
  logic        frame_done;
  logic        overrun;
  logic        proto_err;

  int checks;
  int failures;

  pixel_readout_ctrl_if #(.DATA_W(8), .N_PIX(4)) sink_if ();

  pixel_readout_ctrl #(.DATA_W(8), .N_PIX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read       (read),
    .bias_en    (bias_en),
    .ramp_en    (ramp_en),
    .bus_oe     (bus_oe),
    .dac_code   (dac_code),
    .pix_data   (pix_data),
    .sink       (sink_if),
    .frame_done (frame_done),
    .overrun    (overrun),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t4_words [4];
  int         exp_idx;
  int         exp_dac;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    erase     = 1'b0;
    expose    = 1'b0;
    convert   = 1'b0;
    read      = 1'b0;
    pix_data  = 32'h0;
    sink_if.out_ready = 1'b0;
    t4_words[0] = 8'hA1;
    t4_words[1] = 8'hB2;
    t4_words[2] = 8'hC3;
    t4_words[3] = 8'hD4;

    // T1: reset state, then 255-cycle ramp and drop
    tick();
    tick();
    check("rst_valid",     32'(sink_if.out_valid), 32'd0);
    check("rst_dac",       32'(dac_code),          32'd0);
    check("rst_frame_done",32'(frame_done),        32'd0);
    check("rst_overrun",   32'(overrun),           32'd0);
    check("rst_proto_err", 32'(proto_err),         32'd0);
    check("rst_bias_en",   32'(bias_en),           32'd0);
    check("rst_ramp_en",   32'(ramp_en),           32'd0);
    check("rst_bus_oe",    32'(bus_oe),            32'd0);
    reset   = 1'b0;
    convert = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      check("t1_dac", 32'(dac_code), 32'(k));
    end
    check("t1_ramp_en", 32'(ramp_en), 32'd1);
    check("t1_bus_oe",  32'(bus_oe),  32'd1);
    convert = 1'b0;
    tick();
    check("t1_dac_drop",    32'(dac_code), 32'd0);
    check("t1_ramp_en_off", 32'(ramp_en),  32'd0);
    check("t1_bus_oe_off",  32'(bus_oe),   32'd0);

    // T2: saturation, erase priority, bias_en
    convert = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      exp_dac = (k > 255) ? 255 : k;
      check("t2_dac_sat", 32'(dac_code), 32'(exp_dac));
    end
    erase = 1'b1;
    tick();
    check("t2_erase_dac",  32'(dac_code),  32'd0);
    check("t2_proto_err",  32'(proto_err), 32'd1);
    erase   = 1'b0;
    convert = 1'b0;
    expose  = 1'b1;
    tick();
    check("t2_bias_en", 32'(bias_en), 32'd1);
    expose = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    check("t2_proto_clr", 32'(proto_err), 32'd0);

    // T3: 5-cycle read, sink always ready
    pix_data = 32'h44332211;
    sink_if.out_ready = 1'b1;
    read = 1'b1;
    tick();
    check("t3_settle_valid", 32'(sink_if.out_valid), 32'd0);
    tick();
    check("t3_w0_valid", 32'(sink_if.out_valid), 32'd1);
    check("t3_w0_idx",   32'(sink_if.out_idx),   32'd0);
    check("t3_w0_data",  32'(sink_if.out_data),  32'h11);
    pix_data = 32'hEEEEEEEE;
    tick();
    check("t3_w1_idx",  32'(sink_if.out_idx),  32'd1);
    check("t3_w1_data", 32'(sink_if.out_data), 32'h22);
    tick();
    check("t3_w2_idx",  32'(sink_if.out_idx),  32'd2);
    check("t3_w2_data", 32'(sink_if.out_data), 32'h33);
    tick();
    check("t3_w3_idx",   32'(sink_if.out_idx),  32'd3);
    check("t3_w3_data",  32'(sink_if.out_data), 32'h44);
    check("t3_fd_early", 32'(frame_done),       32'd0);
    read = 1'b0;
    tick();
    check("t3_valid_off", 32'(sink_if.out_valid), 32'd0);
    check("t3_frame_done",32'(frame_done),        32'd1);
    check("t3_overrun",   32'(overrun),           32'd0);
    tick();
    check("t3_fd_pulse", 32'(frame_done), 32'd0);

    // T4: alternating ready, words held while stalled
    pix_data = 32'hD4C3B2A1;
    sink_if.out_ready = 1'b0;
    read = 1'b1;
    tick();
    tick();
    read = 1'b0;
    check("t4_load_idx",  32'(sink_if.out_idx),  32'd0);
    check("t4_load_data", 32'(sink_if.out_data), 32'hA1);
    exp_idx = 0;
    for (int c = 0; c < 8; c++) begin
      sink_if.out_ready = (c % 2 == 1);
      tick();
      if (c % 2 == 1) exp_idx++;
      if (exp_idx < 4) begin
        check("t4_valid", 32'(sink_if.out_valid), 32'd1);
        check("t4_idx",   32'(sink_if.out_idx),   32'(exp_idx));
        check("t4_data",  32'(sink_if.out_data),  32'(t4_words[exp_idx]));
      end else begin
        check("t4_end_valid", 32'(sink_if.out_valid), 32'd0);
        check("t4_end_fd",    32'(frame_done),        32'd1);
      end
    end

    // T5a: capture point with two words pending -> overrun, old frame continues
    sink_if.out_ready = 1'b1;
    pix_data = 32'h04030201;
    read = 1'b1;
    tick();
    tick();
    read = 1'b0;
    pix_data = 32'h0D0C0B0A;
    tick();
    check("t5_idx1", 32'(sink_if.out_idx), 32'd1);
    read = 1'b1;
    tick();
    tick();
    read = 1'b0;
    check("t5_overrun",  32'(overrun),          32'd1);
    check("t5_old_idx",  32'(sink_if.out_idx),  32'd3);
    check("t5_old_data", 32'(sink_if.out_data), 32'h04);
    tick();
    check("t5_drop_valid", 32'(sink_if.out_valid), 32'd0);
    check("t5_drop_fd",    32'(frame_done),        32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_ovr_clr", 32'(overrun), 32'd0);

    // T5b: capture coincides with last handshake -> new frame, no overrun
    pix_data = 32'h04030201;
    read = 1'b1;
    tick();
    tick();
    read = 1'b0;
    tick();
    tick();
    read = 1'b1;
    pix_data = 32'h0D0C0B0A;
    tick();
    check("t5b_last_idx",  32'(sink_if.out_idx),  32'd3);
    check("t5b_last_data", 32'(sink_if.out_data), 32'h04);
    tick();
    read = 1'b0;
    check("t5b_valid",   32'(sink_if.out_valid), 32'd1);
    check("t5b_idx",     32'(sink_if.out_idx),   32'd0);
    check("t5b_data",    32'(sink_if.out_data),  32'h0A);
    check("t5b_overrun", 32'(overrun),           32'd0);
    check("t5b_fd",      32'(frame_done),        32'd1);
    tick();
    check("t5b_next_data", 32'(sink_if.out_data), 32'h0B);

    // T6: reset mid-stream and mid-ramp, then a 1-cycle read pulse
    convert = 1'b1;
    read    = 1'b1;
    tick();
    check("t6_idx2",      32'(sink_if.out_idx), 32'd2);
    check("t6_ramp_dac",  32'(dac_code),        32'd1);
    check("t6_ramp_en",   32'(ramp_en),         32'd1);
    check("t6_bus_oe_rd", 32'(bus_oe),          32'd0);
    check("t6_proto_err", 32'(proto_err),       32'd1);
    read   = 1'b0;
    tick();
    check("t6_bus_oe_on", 32'(bus_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_ramp_en", 32'(ramp_en), 32'd0);
    check("t6_rst_bus_oe",  32'(bus_oe),  32'd0);
    tick();
    check("t6_valid",     32'(sink_if.out_valid), 32'd0);
    check("t6_dac",       32'(dac_code),          32'd0);
    check("t6_fd",        32'(frame_done),        32'd0);
    check("t6_proto_clr", 32'(proto_err),         32'd0);
    check("t6_ovr",       32'(overrun),           32'd0);
    reset   = 1'b0;
    convert = 1'b0;
    tick();
    check("t6_ramp_en_after", 32'(ramp_en), 32'd0);
    read = 1'b1;
    tick();
    read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_pulse_nocap", 32'(sink_if.out_valid), 32'd0);
    end
    check("t6_fd_none", 32'(frame_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
